// File: rtl/uart_usb_packetizer.sv
// rtl/uart_usb_packetizer.sv - UART byte FIFO that groups bytes into packets for a valid/ready USB stream
// A packet closes on length, idle timeout or FIFO full; only closed bytes are presented.
module uart_usb_packetizer #(
  parameter int DEPTH   = 16,
  parameter int MAX_PKT = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       rx_valid_i,
  input  logic [7:0]                 rx_data_i,
  output logic [7:0]                 usb_data_o,
  output logic                       usb_valid_o,
  output logic                       usb_last_o,
  input  logic                       usb_ready_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o,
  input  logic                       clr_ovf_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_PKT + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic {S_IDLE, S_OPEN} state_t;

  logic [8:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, seal_ptr_q, level_q;
  logic [PW-1:0] wr_ptr_d, wr_prev, level_d;
  logic [CW-1:0] pkt_cnt_q, cnt_next;
  logic [TW-1:0] timer_q;
  logic          overflow_q;
  state_t        state_q;

  logic full, accept, drop, pop, valid, fills, seal_on_write, seal_timeout;

  assign full     = (level_q == PW'(DEPTH));
  assign accept   = rx_valid_i && !full;
  assign drop     = rx_valid_i && full;
  assign valid    = (rd_ptr_q != seal_ptr_q);
  assign pop      = valid && usb_ready_i;
  assign wr_ptr_d = wr_ptr_q + PW'(accept);
  assign wr_prev  = wr_ptr_q - PW'(1);
  assign level_d  = level_q + PW'(accept) - PW'(pop);
  assign cnt_next = (state_q == S_OPEN) ? pkt_cnt_q + CW'(1) : CW'(1);

  // "Makes the FIFO full" means full after this cycle's pop, so a concurrent pop defers the seal.
  assign fills         = (level_q == PW'(DEPTH - 1)) && !pop;
  assign seal_on_write = accept && ((cnt_next == CW'(MAX_PKT)) || fills);
  assign seal_timeout  = (state_q == S_OPEN) && !accept && (timer_q == TW'(TIMEOUT - 1));

  // Retro-marking the previous entry is safe: an open entry is never at or behind rd_ptr.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {seal_on_write, rx_data_i};
    end else if (seal_timeout) begin
      mem_q[wr_prev[AW-1:0]][8] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      seal_ptr_q <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      pkt_cnt_q  <= '0;
      timer_q    <= '0;
      state_q    <= S_IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (clr_ovf_i) begin
        overflow_q <= 1'b0;
      end
      if (seal_on_write || seal_timeout) begin
        seal_ptr_q <= wr_ptr_d;
        state_q    <= S_IDLE;
        pkt_cnt_q  <= '0;
        timer_q    <= '0;
      end else if (accept) begin
        state_q   <= S_OPEN;
        pkt_cnt_q <= cnt_next;
        timer_q   <= '0;
      end else if (state_q == S_OPEN) begin
        timer_q <= timer_q + TW'(1);
      end
    end
  end

  assign usb_valid_o = valid;
  assign usb_data_o  = valid ? mem_q[rd_ptr_q[AW-1:0]][7:0] : 8'h00;
  assign usb_last_o  = valid ? mem_q[rd_ptr_q[AW-1:0]][8] : 1'b0;
  assign level_o     = level_q;
  assign overflow_o  = overflow_q;
endmodule

// File: tb/tb_uart_usb_packetizer.sv
// tb/tb_uart_usb_packetizer.sv - Queue-model checker and directed tests for uart_usb_packetizer
module tb_uart_usb_packetizer;
  localparam int DEPTH   = 16;
  localparam int MAX_PKT = 8;
  localparam int TIMEOUT = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] usb_data;
  logic       usb_valid;
  logic       usb_last;
  logic       usb_ready = 1'b0;
  logic [4:0] level;
  logic       overflow;
  logic       clr_ovf = 1'b0;

  uart_usb_packetizer #(.DEPTH(DEPTH), .MAX_PKT(MAX_PKT), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .usb_data_o(usb_data), .usb_valid_o(usb_valid), .usb_last_o(usb_last),
    .usb_ready_i(usb_ready), .level_o(level), .overflow_o(overflow), .clr_ovf_i(clr_ovf)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Model: whole FIFO as a queue; sealed prefix count, open packet size, idle cycles since last byte.
  logic [8:0] m_q[$];
  logic [8:0] got[$];
  logic [8:0] expq[$];
  int  m_sealed = 0, m_open = 0, m_idle = 0;
  bit  m_ovf = 1'b0, m_pop, m_acc, exp_v;
  logic [8:0] tmp;

  task automatic m_seal();
    tmp = m_q.pop_back();
    tmp[8] = 1'b1;
    m_q.push_back(tmp);
    m_sealed += m_open;
    m_open = 0;
    m_idle = 0;
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      m_q.delete();
      m_sealed = 0; m_open = 0; m_idle = 0; m_ovf = 1'b0;
    end else begin
      if (usb_valid && usb_ready) got.push_back({usb_last, usb_data});
      m_pop = (m_sealed > 0) && usb_ready;
      m_acc = rx_valid && (m_q.size() < DEPTH);
      if (rx_valid && !m_acc) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      if (m_pop) begin
        void'(m_q.pop_front());
        m_sealed--;
      end
      if (m_acc) begin
        m_q.push_back({1'b0, rx_data});
        m_open++;
        m_idle = 0;
        if (m_open == MAX_PKT || m_q.size() == DEPTH) m_seal();
      end else if (m_open > 0) begin
        m_idle++;
        if (m_idle == TIMEOUT) m_seal();
      end
    end
    #2;
    exp_v = (m_sealed > 0);
    chk("valid", 32'(usb_valid), 32'(exp_v));
    chk("data", 32'(usb_data), exp_v ? 32'(m_q[0][7:0]) : 32'h0);
    chk("last", 32'(usb_last), exp_v ? 32'(m_q[0][8]) : 32'h0);
    chk("level", 32'(level), 32'(m_q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  end

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!usb_valid && k < TIMEOUT + 10) begin
      @(negedge clk);
      k++;
    end
    chk("wait_valid_bound", 32'(usb_valid), 32'h1);
  endtask

  task automatic wait_empty();
    int k = 0;
    while (level != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("drain_bound", 32'(level), 32'h0);
  endtask

  task automatic check_got(input string nm);
    chk({nm, "_count"}, 32'(got.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++)
      chk(nm, (i < got.size()) ? 32'(got[i]) : 32'hffff, 32'(expq[i]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k;
    tick(2);
    chk("rst_valid", 32'(usb_valid), 32'h0);
    chk("rst_data", 32'(usb_data), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    rst = 1'b1;
    tick(1);

    // T1: length close at MAX_PKT
    usb_ready = 1'b1;
    for (int i = 1; i <= 7; i++) send(8'(i));
    chk("t1_no_valid_before_8th", 32'(usb_valid), 32'h0);
    send(8'h08);
    wait_empty();
    expq.delete();
    for (int i = 1; i <= 8; i++) expq.push_back({(i == 8), 8'(i)});
    check_got("t1_beat");

    // T2: timeout close
    got.delete();
    send(8'hA5); send(8'h5A); send(8'h3C);
    wait_valid(k);
    chk("t2_latency", 32'(k), 32'(TIMEOUT));
    wait_empty();
    expq = '{9'h0A5, 9'h05A, 9'h13C};
    check_got("t2_beat");

    // T3: overflow with consumer stalled, full seal
    got.delete();
    usb_ready = 1'b0;
    for (int i = 0; i < 20; i++) send(8'(i));
    chk("t3_level", 32'(level), 32'd16);
    chk("t3_overflow", 32'(overflow), 32'h1);
    usb_ready = 1'b1;
    wait_empty();
    expq.delete();
    for (int i = 0; i < 16; i++) expq.push_back({(i == 7 || i == 15), 8'(i)});
    check_got("t3_beat");
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    chk("t3_clr_ovf", 32'(overflow), 32'h0);

    // T4: stalls alternate with accepts
    got.delete();
    usb_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'hB0 + 8'(i));
    wait_valid(k);
    for (int i = 0; i < 40 && level != 0; i++) begin
      usb_ready = !usb_ready;
      tick(1);
    end
    usb_ready = 1'b0;
    tick(5);
    expq.delete();
    for (int i = 0; i < 5; i++) expq.push_back({(i == 4), 8'hB0 + 8'(i)});
    check_got("t4_beat");

    // T5: accept and pop together at level 15
    got.delete();
    send(8'h50); send(8'h51); send(8'h52);
    wait_valid(k);
    for (int i = 3; i < 15; i++) send(8'h50 + 8'(i));
    chk("t5_level15", 32'(level), 32'd15);
    rx_valid = 1'b1; rx_data = 8'h5F; usb_ready = 1'b1;
    tick(1);
    rx_valid = 1'b0; usb_ready = 1'b0;
    chk("t5_level_hold", 32'(level), 32'd15);
    chk("t5_no_overflow", 32'(overflow), 32'h0);
    send(8'h60);
    chk("t5_level16", 32'(level), 32'd16);
    usb_ready = 1'b1;
    wait_empty();
    expq.delete();
    for (int i = 0; i < 17; i++) expq.push_back({(i == 2 || i == 10 || i == 16), 8'h50 + 8'(i)});
    check_got("t5_beat");

    // T6: reset with a sealed packet pending and an open one
    usb_ready = 1'b0;
    send(8'h70); send(8'h71);
    wait_valid(k);
    send(8'h72); send(8'h73); send(8'h74);
    rst = 1'b0;
    #1;
    chk("t6_valid", 32'(usb_valid), 32'h0);
    chk("t6_data", 32'(usb_data), 32'h0);
    chk("t6_last", 32'(usb_last), 32'h0);
    chk("t6_level", 32'(level), 32'h0);
    chk("t6_overflow", 32'(overflow), 32'h0);
    tick(1);
    rst = 1'b1;
    got.delete();
    usb_ready = 1'b1;
    send(8'hC1); send(8'hC2);
    wait_valid(k);
    wait_empty();
    expq = '{9'h0C1, 9'h1C2};
    check_got("t6_beat");

    tick(3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
